// File: rtl/blk_mem_port_arbiter.sv
// blk_mem_port_arbiter
// Shares port A of the dual-port block-memory wrapper between two requesters
// on clock domain A using round-robin arbitration.
//   clk_a, arstz_aq          : clock and asynchronous active-low reset
//   req{0,1}_en/we/addr/din  : requester commands, held until granted
//   req{0,1}_gnt             : one-cycle pulse, command issued this cycle
//   req{0,1}_rvalid/rdata    : one-cycle read response, shared data register
//   mem_en/we/addr/din       : command to the wrapper port A
//   mem_dout/mem_valid       : read return from the wrapper port A
//   clr_err / timeout_err    : clear and sticky read-watchdog flag
// Writes issue combinationally in IDLE with no added latency. A read blocks
// further grants until its response (or watchdog abort) has been returned.
module blk_mem_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_a,
  input  logic                  arstz_aq,
  input  logic                  req0_en,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_din,
  input  logic                  req1_en,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_din,
  output logic                  req0_gnt,
  output logic                  req1_gnt,
  output logic                  req0_rvalid,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_valid,
  input  logic                  clr_err,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  // Watchdog aborts on the cycle the counter reaches this value.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  owner_q, owner_d;
  logic [7:0]            wd_cnt_q, wd_cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  win_valid_s;
  logic                  win_s;
  logic                  issue_s;
  logic                  abort_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_din_s;

  // Round-robin winner: on a tie the requester not granted last wins.
  always_comb begin
    win_valid_s = 1'b0;
    win_s       = 1'b0;
    if (req0_en && req1_en) begin
      win_valid_s = 1'b1;
      win_s       = ~last_gnt_q;
    end else if (req0_en) begin
      win_valid_s = 1'b1;
      win_s       = 1'b0;
    end else if (req1_en) begin
      win_valid_s = 1'b1;
      win_s       = 1'b1;
    end else begin
      win_valid_s = 1'b0;
      win_s       = 1'b0;
    end
  end

  assign sel_we_s   = win_s ? req1_we   : req0_we;
  assign sel_addr_s = win_s ? req1_addr : req0_addr;
  assign sel_din_s  = win_s ? req1_din  : req0_din;

  // Next-state logic for the issue / read-wait / response sequence.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    wd_cnt_d   = wd_cnt_q;
    rdata_d    = rdata_q;
    issue_s    = 1'b0;
    abort_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          issue_s    = 1'b1;
          last_gnt_d = win_s;
          if (!sel_we_s) begin
            state_d  = RD_WAIT;
            owner_d  = win_s;
            wd_cnt_d = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (mem_valid) begin
          rdata_d = mem_dout;
          state_d = RESP;
        end else if (wd_cnt_q == WD_LAST) begin
          rdata_d = {DATA_WIDTH{1'b0}};
          abort_s = 1'b1;
          state_d = RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky watchdog flag; a new abort outranks a simultaneous clear.
  always_comb begin
    if (abort_s) begin
      timeout_err_d = 1'b1;
    end else if (clr_err) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      state_q       <= IDLE;
      last_gnt_q    <= 1'b1;
      owner_q       <= 1'b0;
      wd_cnt_q      <= 8'd0;
      rdata_q       <= {DATA_WIDTH{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_gnt_q    <= last_gnt_d;
      owner_q       <= owner_d;
      wd_cnt_q      <= wd_cnt_d;
      rdata_q       <= rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Issue outputs are combinational from the requests, so they are gated by
  // reset to keep the wrapper port quiet while reset is asserted.
  assign req0_gnt = issue_s & ~win_s & arstz_aq;
  assign req1_gnt = issue_s &  win_s & arstz_aq;
  assign mem_en   = issue_s & arstz_aq;
  assign mem_we   = issue_s & sel_we_s & arstz_aq;
  assign mem_addr = (issue_s & arstz_aq) ? sel_addr_s : {ADDR_WIDTH{1'b0}};
  assign mem_din  = (issue_s & arstz_aq) ? sel_din_s  : {DATA_WIDTH{1'b0}};

  assign req0_rvalid = (state_q == RESP) && !owner_q;
  assign req1_rvalid = (state_q == RESP) &&  owner_q;
  assign req0_rdata  = rdata_q;
  assign req1_rdata  = rdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_blk_mem_port_arbiter.sv
// tb_blk_mem_port_arbiter
// Drives both requesters, models the block-memory wrapper (configurable read
// latency or never-valid), and checks every cycle against a transaction-level
// reference built from cycle arithmetic: a read granted at cycle g answers at
// g+L+1 (or g+TIMEOUT+1 when aborted) and blocks grants until one cycle later.
module tb_blk_mem_port_arbiter;

  localparam int TO = 15;

  logic        clk_a = 1'b0;
  logic        arstz_aq;
  logic        r_en   [0:1];
  logic        r_we   [0:1];
  logic [11:0] r_addr [0:1];
  logic [31:0] r_din  [0:1];
  logic        hold   [0:1];
  logic        clr_err;
  logic        req0_gnt, req1_gnt, req0_rvalid, req1_rvalid;
  logic [31:0] req0_rdata, req1_rdata;
  logic        mem_en, mem_we, mem_valid, timeout_err;
  logic [11:0] mem_addr;
  logic [31:0] mem_din, mem_dout;

  // wrapper model
  logic [31:0] wmem [0:1023];
  logic [3:0]  sr_v;
  logic [31:0] sr_d [0:3];
  logic [1:0]  lat_sel;
  logic        never_valid;
  logic        spur;

  // reference model
  logic [31:0] rmem [0:1023];
  int          cyc, lat, m_free, m_rsp, m_abort, m_owner;
  logic        m_last, m_err;
  logic [31:0] m_data;
  int          total, bad;

  always #5 clk_a = ~clk_a;

  blk_mem_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk_a(clk_a), .arstz_aq(arstz_aq),
    .req0_en(r_en[0]), .req0_we(r_we[0]), .req0_addr(r_addr[0]), .req0_din(r_din[0]),
    .req1_en(r_en[1]), .req1_we(r_we[1]), .req1_addr(r_addr[1]), .req1_din(r_din[1]),
    .req0_gnt(req0_gnt), .req1_gnt(req1_gnt),
    .req0_rvalid(req0_rvalid), .req1_rvalid(req1_rvalid),
    .req0_rdata(req0_rdata), .req1_rdata(req1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_valid(mem_valid),
    .clr_err(clr_err), .timeout_err(timeout_err)
  );

  // Wrapper port A: fixed-latency read pipeline, writes land at the clock edge.
  always @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      sr_v <= 4'd0;
    end else begin
      sr_v    <= {sr_v[2:0], mem_en & ~mem_we};
      sr_d[3] <= sr_d[2];
      sr_d[2] <= sr_d[1];
      sr_d[1] <= sr_d[0];
      sr_d[0] <= wmem[mem_addr[11:2]];
      if (mem_en && mem_we) wmem[mem_addr[11:2]] <= mem_din;
    end
  end

  assign mem_valid = spur | (~never_valid & sr_v[lat_sel]);
  assign mem_dout  = sr_d[lat_sel];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  task automatic set_lat(input int l);
    lat     = l;
    lat_sel = 2'(l - 1);
  endtask

  task automatic model_reset();
    cyc = 0; m_free = 0; m_rsp = -1; m_abort = -1; m_owner = 0;
    m_last = 1'b1; m_err = 1'b0; m_data = 32'd0;
  endtask

  task automatic chk_rst_outputs();
    chk("rst_gnt0", 32'(req0_gnt), 32'd0);
    chk("rst_gnt1", 32'(req1_gnt), 32'd0);
    chk("rst_rv0", 32'(req0_rvalid), 32'd0);
    chk("rst_rv1", 32'(req1_rvalid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_rdata", req0_rdata, 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
  endtask

  task automatic set_req(input int id, input logic we, input logic [11:0] a, input logic [31:0] d);
    r_en[id] = 1'b1; r_we[id] = we; r_addr[id] = a; r_din[id] = d;
  endtask

  // One clock cycle: check DUT against the model, advance the model, release
  // granted non-held requests after the edge.
  task automatic tick();
    int  w;
    logic rv;
    #3;
    w = -1;
    if (cyc >= m_free) begin
      if (r_en[0] && r_en[1]) w = m_last ? 0 : 1;
      else if (r_en[0])       w = 0;
      else if (r_en[1])       w = 1;
    end
    chk("gnt0", 32'(req0_gnt), 32'(w == 0));
    chk("gnt1", 32'(req1_gnt), 32'(w == 1));
    chk("mem_en", 32'(mem_en), 32'(w >= 0));
    if (w >= 0) begin
      chk("mem_we", 32'(mem_we), 32'(r_we[w]));
      chk("mem_addr", 32'(mem_addr), 32'(r_addr[w]));
      if (r_we[w]) chk("mem_din", mem_din, r_din[w]);
    end
    rv = (cyc == m_rsp);
    chk("rvalid0", 32'(req0_rvalid), 32'(rv && m_owner == 0));
    chk("rvalid1", 32'(req1_rvalid), 32'(rv && m_owner == 1));
    if (rv) chk(m_owner == 0 ? "rdata0" : "rdata1", m_owner == 0 ? req0_rdata : req1_rdata, m_data);
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
    if (cyc == m_abort) m_err = 1'b1;
    else if (clr_err)   m_err = 1'b0;
    if (w >= 0) begin
      m_last = (w == 1);
      if (r_we[w]) begin
        rmem[r_addr[w][11:2]] = r_din[w];
      end else begin
        m_owner = w;
        if (never_valid) begin
          m_rsp = cyc + TO + 1; m_abort = cyc + TO; m_data = 32'd0;
        end else begin
          m_rsp = cyc + lat + 1; m_abort = -1; m_data = rmem[r_addr[w][11:2]];
        end
        m_free = m_rsp + 1;
      end
    end
    @(posedge clk_a);
    #1;
    cyc++;
    if (w >= 0 && !hold[w]) r_en[w] = 1'b0;
  endtask

  task automatic drain();
    r_en[0] = 1'b0; r_en[1] = 1'b0; hold[0] = 1'b0; hold[1] = 1'b0;
    repeat (TO + 4) tick();
  endtask

  initial begin
    total = 0; bad = 0;
    arstz_aq = 1'b0; clr_err = 1'b0; never_valid = 1'b0; spur = 1'b1;
    set_lat(1);
    model_reset();
    for (int i = 0; i < 1024; i++) begin
      rmem[i] = $urandom; wmem[i] = rmem[i];
    end
    rmem[12'h040 >> 2] = 32'hDEADBEEF; wmem[12'h040 >> 2] = 32'hDEADBEEF;
    set_req(0, 1'b1, 12'h010, 32'hAAAA0000);
    set_req(1, 1'b1, 12'h020, 32'hBBBB0000);
    hold[0] = 1'b1; hold[1] = 1'b1;

    // reset held with both requesting, stray mem_valid present
    repeat (3) @(posedge clk_a);
    #4;
    chk_rst_outputs();
    @(posedge clk_a);
    #1;
    arstz_aq = 1'b1;

    // alternating back-to-back writes; mem_valid noise outside RD_WAIT
    repeat (8) tick();
    spur = 1'b0;
    drain();

    // read latency 1 and 3 of the preloaded word
    set_req(1, 1'b0, 12'h040, 32'd0);
    repeat (4) tick();
    set_lat(3);
    set_req(1, 1'b0, 12'h040, 32'd0);
    repeat (6) tick();

    // contention: req0 reads continuously, req1 write waits for L+2
    set_lat(2);
    hold[0] = 1'b1;
    set_req(0, 1'b0, 12'h040, 32'd0);
    tick();
    set_req(1, 1'b1, 12'h100, 32'h12345678);
    repeat (10) tick();
    drain();

    // watchdog abort, clear, then abort coinciding with clear
    never_valid = 1'b1;
    set_req(0, 1'b0, 12'h080, 32'd0);
    repeat (TO + 2) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    repeat (2) tick();
    set_req(0, 1'b0, 12'h084, 32'd0);
    repeat (TO) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    repeat (3) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    never_valid = 1'b0;
    drain();

    // randomized traffic at each latency
    for (int l = 1; l <= 3; l++) begin
      set_lat(l);
      for (int n = 0; n < 300; n++) begin
        for (int id = 0; id < 2; id++) begin
          if (!r_en[id]) begin
            if ($urandom_range(0, 1) == 1)
              set_req(id, 1'($urandom_range(0, 1)), {4'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
          end else if ($urandom_range(0, 15) == 0) begin
            r_en[id] = 1'b0;
          end
        end
        clr_err = ($urandom_range(0, 31) == 0);
        tick();
      end
      clr_err = 1'b0;
      drain();
    end

    // reset in the middle of a read: response dropped, fresh start after
    set_lat(3);
    set_req(1, 1'b0, 12'h040, 32'd0);
    repeat (2) tick();
    arstz_aq = 1'b0;
    set_req(0, 1'b1, 12'h010, 32'h0000AAAA);
    set_req(1, 1'b1, 12'h020, 32'h0000BBBB);
    #3;
    chk_rst_outputs();
    repeat (3) begin
      @(posedge clk_a);
      #4;
      chk("rst_mid_rv0", 32'(req0_rvalid), 32'd0);
      chk("rst_mid_rv1", 32'(req1_rvalid), 32'd0);
      chk("rst_mid_en", 32'(mem_en), 32'd0);
    end
    @(posedge clk_a);
    #1;
    arstz_aq = 1'b1;
    model_reset();
    repeat (6) tick();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blk_mem_port_arbiter.md
# blk_mem_port_arbiter

Two-requester round-robin arbiter that shares port A of the dual-port block-memory wrapper between two masters on clock domain A, e.g. the DMA loader and the CNN core. It passes single-cycle writes straight through. For reads it tracks the single outstanding transaction until the wrapper's valid pulse, then returns registered data to the owning requester. A watchdog flags reads that never complete.

## Interface
- ADDR_WIDTH, 12, byte address width; matches wrapper port.
- DATA_WIDTH, 32, data width.
- TIMEOUT, 15, max cycles in RD_WAIT before abort; 1..255.
- clk_a  in  1  clock.
- arstz_aq  in  1  reset: arstz_aq, asynchronous, active-low; clock clk_a.
- req0_en / req1_en  in  1  request; held until matching gnt.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  ADDR_WIDTH  byte address.
- req0_din / req1_din  in  DATA_WIDTH  write data.
- req0_gnt / req1_gnt  out  1  one-cycle pulse: command accepted and issued this cycle.
- req0_rvalid / req1_rvalid  out  1  one-cycle pulse: read data valid.
- req0_rdata / req1_rdata  out  DATA_WIDTH  read data, registered, shared register.
- mem_en, mem_we  out  1  to wrapper port A.
- mem_addr  out  ADDR_WIDTH; mem_din  out  DATA_WIDTH.
- mem_dout  in  DATA_WIDTH; mem_valid  in  1  from wrapper port A.
- clr_err  in  1  clears timeout_err.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE: if any reqN_en, pick winner. Drive mem_en=1, mem_we/addr/din from the winner, and reqN_gnt=1, all combinationally in the same cycle.
  - Winner is a write: stay in IDLE. The next command can issue the next cycle.
  - Winner is a read: go to RD_WAIT; owner = winner; wd_cnt = 0.
- RD_WAIT: mem_en=0, no grants.
  - On mem_valid: capture mem_dout into rdata, go to RESP.
  - Otherwise wd_cnt++. When wd_cnt == TIMEOUT-1 without valid: rdata = 0, set timeout_err, go to RESP.
- RESP: assert reqN_rvalid for the owner only, for one cycle. No grants. Go to IDLE.
- Arbitration: round-robin on last_gnt. If both request, grant the one not granted last. If one requests, grant it regardless of last_gnt. last_gnt updates on every grant, read or write. Request type does not affect priority.
- mem_valid outside RD_WAIT is ignored.
- timeout_err: set by an abort, cleared by clr_err. Set wins when both occur in the same cycle.
- A requester dropping reqN_en before gnt is legal; the request is simply withdrawn.

## Timing
- Reset values:
  - state IDLE, last_gnt = 1 (req0 wins the first tie), wd_cnt 0, rdata 0, timeout_err 0.
  - All gnt/rvalid/mem_* outputs 0 while in reset.
- Write: issued in the gnt cycle, 0 extra latency. Back-to-back writes reach 1 per cycle, alternating between requesters when both request.
- Read, wrapper READ_LATENCY = L:
  - gnt at cycle 0.
  - mem_valid at cycle L.
  - rvalid with data at cycle L+1.
  - Next grant possible at cycle L+2.
- Abort: rvalid at cycle TIMEOUT+1 after gnt, with rdata = 0.
- Reset mid-read: the response is dropped and no rvalid is produced. The wrapper shares arstz_aq, so both sides restart in IDLE.

## Test plan
- Reset: hold arstz_aq = 0 with req0_en = req1_en = 1 → all outputs 0. Release → cycle 0: req0_gnt = 1.
- Alternating writes: both requesters issue writes continuously, req0 to 0x010 with 0xAAAA0000, req1 to 0x020 with 0xBBBB0000 → gnts alternate 0,1,0,1 at 1 per cycle; mem_addr/mem_din match the granted requester each cycle.
- Read latency, READ_LATENCY = 1 model: mem word 0x040 preloaded 0xDEADBEEF; req1 reads 0x040 → req1_gnt at cycle 0, req1_rvalid at cycle 2 with 0xDEADBEEF; req0_rvalid stays 0.
- Read latency, READ_LATENCY = 3 model: same read → rvalid at cycle 4.
- Contention: req0 reads while req1 requests a write → the req1 write is granted only at cycle L+2 after the read gnt, and req0 is not granted again before req1.
- Watchdog: memory model never asserts mem_valid; req0 reads → req0_rvalid at cycle 16 with rdata = 0, timeout_err = 1. Pulse clr_err → 0. Abort and clr_err in the same cycle → timeout_err stays 1.
